// File: rtl/mem_access_unit.sv
// Initiator side of the 8-bit data memory: byte / 16-bit little-endian loads and stores
// split into single-byte beats. Optional macro: MAU_WRAP_ERR_EN (wide access at all-ones address errors out).
module mem_access_unit #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic            req_wide,
    input  logic [AW-1:0]   req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [2*DW-1:0] resp_rdata,
    output logic            resp_err,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_write,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a response holds valid and data stable until resp_ready is seen.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic            we_q;
    logic            wide_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_hi_q;
    logic [2*DW-1:0] rdata_q;
    logic            err_q;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_write_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            wrap_hit;

`ifdef MAU_WRAP_ERR_EN
    assign wrap_hit = req_wide & (&req_addr);
`else
    assign wrap_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            wide_q      <= 1'b0;
            addr_q      <= '0;
            wdata_hi_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_write_q <= 1'b0;
                    if (req_valid) begin
                        we_q       <= req_we;
                        wide_q     <= req_wide;
                        addr_q     <= req_addr;
                        wdata_hi_q <= req_wdata[2*DW-1:DW];
                        rdata_q    <= '0;
                        if (wrap_hit) begin
                            // Wrapping wide access: no beat at all, straight to an error response.
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            mem_addr_q  <= req_addr;
                            mem_write_q <= req_we;
                            mem_wdata_q <= req_wdata[DW-1:0];
                            state_q     <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (!we_q) rdata_q[DW-1:0] <= mem_rdata;
                    if (wide_q) begin
                        mem_addr_q  <= addr_q + AW'(1);
                        mem_wdata_q <= wdata_hi_q;
                        mem_write_q <= we_q;
                        state_q     <= BEAT1;
                    end else begin
                        mem_write_q <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                BEAT1: begin
                    if (!we_q) rdata_q[2*DW-1:DW] <= mem_rdata;
                    mem_write_q <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    mem_write_q <= 1'b0;
                    if (resp_ready) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;
    assign dbg_state  = state_q;

endmodule
